register_skid_arst: RTL

REGISTER_SKID_ARST -- requirements
Module: register_skid_arst

---
 rtl/register_skid_arst.sv | 80 ++++++++
 1 files changed

// File: rtl/register_skid_arst.sv
// Two-entry register slice with a skid buffer: every output is driven from flops,
// so no combinational path crosses the block in either direction.
module register_skid_arst #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_EMPTY = 2'd1,
      ST_ONE   = 2'd2,
      ST_TWO   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q,  main_d;
   logic [WIDTH-1:0] skid_q,  skid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Handshake inputs are only consulted in states where the matching ready/valid is 1,
   // so s_valid in TWO and m_ready in EMPTY never move data.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         ST_INIT: state_d = ST_EMPTY;
         ST_EMPTY: begin
            if (s_valid) begin
               main_d  = s_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            unique case ({s_valid, m_ready})
               2'b10: begin
                  skid_d  = s_data;
                  state_d = ST_TWO;
               end
               2'b01: state_d = ST_EMPTY;
               2'b11: main_d = s_data;
               default: state_d = ST_ONE;
            endcase
         end
         ST_TWO: begin
            if (m_ready) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   assign s_ready     = (state_q == ST_EMPTY) || (state_q == ST_ONE);
   assign m_valid     = (state_q == ST_ONE) || (state_q == ST_TWO);
   assign m_data      = main_q;
   assign dbg_state_o = state_q;

endmodule
